// File: rtl/io_latch_timer.sv
// IO bus cycle latch with a no-response timer: tracks one outstanding IO cycle,
// completes it on device acknowledge or declares a sticky non-existent device.
module io_latch_timer #(
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT_COUNT = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     io_start,
  input  logic                     io_ack,
  input  logic                     nxd_clr,
  output logic                     iolatch,
  output logic                     io_done,
  output logic                     nxd,
  output logic [TIMEOUT_WIDTH-1:0] io_timer
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_COUNT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE  = TIMEOUT_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]   timer_q, timer_d;
  logic                       done_q,  done_d;
  logic                       nxd_q,   nxd_d;

  // State register; reset overrides clken and every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      done_q  <= 1'b0;
      nxd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      nxd_q   <= nxd_d;
    end
  end

  // Next-state logic; done_d defaults low so the pulse drops on any clk edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    nxd_d   = nxd_q;
    if (clken) begin
      if (nxd_clr) begin
        nxd_d = 1'b0;
      end else begin
        nxd_d = nxd_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (io_start) begin
            state_d = ST_BUSY;
            timer_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Acknowledge outranks the timeout; a timeout outranks nxd_clr.
          if (io_ack) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            state_d = ST_IDLE;
            nxd_d   = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    iolatch  = (state_q == ST_BUSY);
    io_done  = done_q;
    nxd      = nxd_q;
    io_timer = timer_q;
  end

endmodule

// File: tb/tb_io_latch_timer.sv
// Self-checking bench for io_latch_timer (TIMEOUT_WIDTH=4, TIMEOUT_COUNT=10).
module tb_io_latch_timer;

  logic       clk;
  logic       rst;
  logic       clken;
  logic       io_start;
  logic       io_ack;
  logic       nxd_clr;
  logic       iolatch;
  logic       io_done;
  logic       nxd;
  logic [3:0] io_timer;

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  typedef struct {
    logic       clken;
    logic       start;
    logic       ack;
    logic       clr;
    logic       rst;
    logic       latch;
    logic       done;
    logic       nxd;
    logic [3:0] timer;
  } vec_t;

  typedef struct {
    int         id;
    logic       latch;
    logic       done;
    logic       nxd;
    logic [3:0] timer;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  io_latch_timer #(
    .TIMEOUT_WIDTH(4),
    .TIMEOUT_COUNT(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .io_start (io_start),
    .io_ack   (io_ack),
    .nxd_clr  (nxd_clr),
    .iolatch  (iolatch),
    .io_done  (io_done),
    .nxd      (nxd),
    .io_timer (io_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic s, input logic a, input logic cl,
                              input logic r, input logic el, input logic ed, input logic en,
                              input logic [3:0] et);
    vec_t v;
    v.clken = c;  v.start = s; v.ack = a; v.clr = cl; v.rst = r;
    v.latch = el; v.done = ed; v.nxd = en; v.timer = et;
    return v;
  endfunction

  // Drive one edge of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    clken    = v.clken;
    io_start = v.start;
    io_ack   = v.ack;
    nxd_clr  = v.clr;
    rst      = v.rst;
    e.id = vec_id; e.latch = v.latch; e.done = v.done; e.nxd = v.nxd; e.timer = v.timer;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued at vector %0d", vec_id - 1);
    end else begin
      got = exp_q.pop_front();
      if (iolatch !== got.latch || io_done !== got.done || nxd !== got.nxd || io_timer !== got.timer) begin
        errors++;
        $display("FAIL vec%0d: got iolatch=%b io_done=%b nxd=%b io_timer=%0d, required iolatch=%b io_done=%b nxd=%b io_timer=%0d",
                 got.id, iolatch, io_done, nxd, io_timer, got.latch, got.done, got.nxd, got.timer);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clken = 1'b0; io_start = 1'b0; io_ack = 1'b0; nxd_clr = 1'b0;

    // clken, start, ack, clr, rst | iolatch, io_done, nxd, io_timer
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 4'd0));
    // Acknowledged cycle: ack at edge 3
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd2));
    // Ack ignored in idle; start ignored while clken=0
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 4'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 4'd2));
    // Start held through a completed cycle
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'd1));
    // Reset beats start and clken
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 4'd0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Timeout: iolatch high after edges 0-9, low with nxd after edge 10
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int k = 1; k <= 9; k++)
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k)));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9));

    // Ack coincident with the final timer value wins over timeout
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int k = 1; k <= 9; k++)
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k)));
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9));

    // clken toggling: timer moves only on enabled edges; set beats nxd_clr
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int k = 1; k <= 9; k++) begin
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k - 1)));
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k)));
    end
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9));
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));

    // nxd_clr with io_start, then reset mid-cycle aborts without flags
    apply(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int k = 1; k <= 5; k++)
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k)));
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
